// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer and its stall timer.
package pc_seq_pkg;

  // Sequencer states: normal flow, load-use countdown, waiting on imem,
  // and holding a redirect that could not be issued yet.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_REDIR   = 2'd3
  } seq_state_t;

  // Sequential fetch stride in bytes.
  localparam int PC_INC = 4;

  // Default datapath/address width.
  localparam int WL_DEF = 32;

  // Width of the load-use stall counter (supports up to 7 stall cycles).
  localparam int LU_W = 3;

endpackage

// File: rtl/stall_timer.sv
// Small down-counter used to time load-use stalls. Load wins over
// decrement, clear wins over everything; it parks at zero.
module stall_timer
  import pc_seq_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            clear,
  input  logic            load,
  input  logic [LU_W-1:0] load_val,
  input  logic            dec,
  output logic [LU_W-1:0] count,
  output logic            zero
);

  // Counter register: reset/clear, (re)load, or count down toward zero.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LU_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline stall/flush control. All outputs are
// combinational so the PC register consumes them at the same edge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WL     = WL_DEF,
  parameter int LU_CYC = 1
)
(
  input  logic          CLK,
  input  logic          RST,
  input  logic [WL-1:0] PC,
  input  logic          br_taken,
  input  logic [WL-1:0] br_target,
  input  logic          jmp,
  input  logic [WL-1:0] jmp_target,
  input  logic          lu_hazard,
  input  logic          imem_ready,
  output logic [WL-1:0] PC_,
  output logic          stall,
  output logic          flush_ifid,
  output logic          flush_idex,
  output logic          tgt_err
);

  seq_state_t      state;
  seq_state_t      state_next;
  logic [WL-1:0]   pend_tgt;
  logic [WL-1:0]   pend_tgt_next;
  logic            pend_is_br;
  logic            pend_is_br_next;
  logic            pend_valid_next;
  logic [WL-1:0]   pc_inc;
  logic            mem_busy;
  logic            hold_busy;
  logic            stall_raw;
  logic            timer_zero;
  logic [LU_W-1:0] timer_count;

  // A taken branch squashes the hazarding instruction, so it clears the
  // countdown and suppresses a simultaneous reload.
  stall_timer u_stall_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (br_taken),
    .load     (lu_hazard & ~br_taken),
    .load_val (LU_W'(LU_CYC - 1)),
    .dec      (1'b1),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // Next-PC, stall/flush outputs, pending-redirect update and next state.
  always_comb begin
    pc_inc          = PC + WL'(PC_INC);
    mem_busy        = ~imem_ready;
    hold_busy       = lu_hazard | ~timer_zero;
    stall_raw       = hold_busy | mem_busy;

    PC_             = pc_inc;
    stall           = 1'b0;
    flush_ifid      = 1'b0;
    flush_idex      = 1'b0;
    pend_valid_next = (state == ST_REDIR);
    pend_is_br_next = pend_is_br;
    pend_tgt_next   = pend_tgt;
    state_next      = ST_RUN;

    if (br_taken) begin
      PC_        = br_target;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      if (mem_busy) begin
        pend_valid_next = 1'b1;
        pend_is_br_next = 1'b1;
        pend_tgt_next   = br_target;
      end else begin
        pend_valid_next = 1'b0;
        pend_is_br_next = 1'b0;
      end
    end else if (jmp) begin
      PC_ = jmp_target;
      if (stall_raw) begin
        stall = 1'b1;
        if (!((state == ST_REDIR) && pend_is_br)) begin
          pend_valid_next = 1'b1;
          pend_is_br_next = 1'b0;
          pend_tgt_next   = jmp_target;
        end
      end else begin
        flush_ifid      = 1'b1;
        pend_valid_next = 1'b0;
        pend_is_br_next = 1'b0;
      end
    end else if ((state == ST_REDIR) && imem_ready && !hold_busy) begin
      PC_             = pend_tgt;
      flush_ifid      = 1'b1;
      pend_valid_next = 1'b0;
      pend_is_br_next = 1'b0;
    end else begin
      stall = stall_raw;
    end

    if (pend_valid_next) begin
      state_next = ST_REDIR;
    end else if (!br_taken && mem_busy) begin
      state_next = ST_MEMWAIT;
    end else if (!br_taken && (lu_hazard ? (LU_CYC > 1) : (timer_count > LU_W'(1)))) begin
      state_next = ST_HOLD;
    end else begin
      state_next = ST_RUN;
    end

    if (RST) begin
      PC_             = pc_inc;
      stall           = 1'b0;
      flush_ifid      = 1'b0;
      flush_idex      = 1'b0;
      pend_valid_next = 1'b0;
      pend_is_br_next = 1'b0;
      pend_tgt_next   = '0;
      state_next      = ST_RUN;
    end
  end

  // State and pending-redirect registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_RUN;
      pend_tgt   <= '0;
      pend_is_br <= 1'b0;
    end else begin
      state      <= state_next;
      pend_tgt   <= pend_tgt_next;
      pend_is_br <= pend_is_br_next;
    end
  end

  // Sticky flag for an issued zero next-PC, which the PC register ignores.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tgt_err <= 1'b0;
    end else if (!stall && (PC_ == '0)) begin
      tgt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (LU_CYC=2).
module tb_pc_sequencer;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        lu_hazard;
  logic        imem_ready;
  logic [31:0] PC_;
  logic        stall;
  logic        flush_ifid;
  logic        flush_idex;
  logic        tgt_err;

  int checks;
  int failures;

  pc_sequencer #(.WL(32), .LU_CYC(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC         (PC),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .lu_hazard  (lu_hazard),
    .imem_ready (imem_ready),
    .PC_        (PC_),
    .stall      (stall),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .tgt_err    (tgt_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlow(input string tag, input logic [31:0] pc_exp, input logic st_exp,
                           input logic fi_exp, input logic fe_exp);
    checkOutput({tag, "_pc"}, PC_, pc_exp);
    checkOutput({tag, "_stall"}, {31'b0, stall}, {31'b0, st_exp});
    checkOutput({tag, "_fifid"}, {31'b0, flush_ifid}, {31'b0, fi_exp});
    checkOutput({tag, "_fidex"}, {31'b0, flush_idex}, {31'b0, fe_exp});
  endtask

  task automatic checkStall(input string tag, input logic st_exp, input logic fi_exp);
    checkOutput({tag, "_stall"}, {31'b0, stall}, {31'b0, st_exp});
    checkOutput({tag, "_fifid"}, {31'b0, flush_ifid}, {31'b0, fi_exp});
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic br, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic lu,
                               input logic rdy);
    PC         = pc;
    br_taken   = br;
    br_target  = bt;
    jmp        = j;
    jmp_target = jt;
    lu_hazard  = lu;
    imem_ready = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with idle inputs
    RST = 1'b1;
    applyStimulus(32'h100, 0, 0, 0, 0, 0, 1);
    checkFlow("rst", 32'h104, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_tgterr", {31'b0, tgt_err}, 32'h0);
    RST = 1'b0;

    // Sequential run
    applyStimulus(32'h100, 0, 0, 0, 0, 0, 1);
    checkFlow("seq", 32'h104, 0, 0, 0);
    tick();

    // Load-use stall of two cycles
    applyStimulus(32'h200, 0, 0, 0, 0, 1, 1);
    checkStall("lu_c0", 1, 0);
    tick();
    applyStimulus(32'h200, 0, 0, 0, 0, 0, 1);
    checkStall("lu_c1", 1, 0);
    tick();
    applyStimulus(32'h200, 0, 0, 0, 0, 0, 1);
    checkFlow("lu_c2", 32'h204, 0, 0, 0);
    tick();

    // Branch and jump together during HOLD: branch wins
    applyStimulus(32'h204, 0, 0, 0, 0, 1, 1);
    checkStall("hold_in", 1, 0);
    tick();
    applyStimulus(32'h204, 1, 32'h400, 1, 32'h800, 0, 1);
    checkFlow("brjmp", 32'h400, 0, 1, 1);
    tick();
    applyStimulus(32'h400, 0, 0, 0, 0, 0, 1);
    checkFlow("brjmp_after", 32'h404, 0, 0, 0);
    tick();

    // imem not ready for three cycles, jump arrives in the first
    applyStimulus(32'h404, 0, 0, 1, 32'h300, 0, 0);
    checkStall("mw_c1", 1, 0);
    tick();
    applyStimulus(32'h404, 0, 0, 0, 0, 0, 0);
    checkStall("mw_c2", 1, 0);
    tick();
    applyStimulus(32'h404, 0, 0, 0, 0, 0, 0);
    checkStall("mw_c3", 1, 0);
    tick();
    applyStimulus(32'h404, 0, 0, 0, 0, 0, 1);
    checkFlow("mw_rdy", 32'h300, 0, 1, 0);
    tick();
    applyStimulus(32'h300, 0, 0, 0, 0, 0, 1);
    checkFlow("mw_after", 32'h304, 0, 0, 0);
    tick();

    // Pending overwrite: branch replaces jump, later jump cannot replace branch
    applyStimulus(32'h304, 0, 0, 1, 32'h600, 0, 0);
    checkStall("ow_jmp", 1, 0);
    tick();
    applyStimulus(32'h304, 1, 32'h700, 0, 0, 0, 0);
    checkFlow("ow_br", 32'h700, 0, 1, 1);
    tick();
    applyStimulus(32'h700, 0, 0, 1, 32'h900, 0, 0);
    checkStall("ow_jmp2", 1, 0);
    tick();
    applyStimulus(32'h700, 0, 0, 0, 0, 0, 1);
    checkFlow("ow_rdy", 32'h700, 0, 1, 0);
    tick();
    applyStimulus(32'h700, 0, 0, 0, 0, 0, 1);
    checkFlow("ow_after", 32'h704, 0, 0, 0);
    tick();

    // Plain imem wait without redirect
    applyStimulus(32'h704, 0, 0, 0, 0, 0, 0);
    checkStall("wait", 1, 0);
    tick();
    applyStimulus(32'h704, 0, 0, 0, 0, 0, 1);
    checkFlow("wait_rdy", 32'h708, 0, 0, 0);
    tick();

    // Reset while a jump to 0x500 is pending
    applyStimulus(32'h708, 0, 0, 1, 32'h500, 0, 0);
    checkStall("rd_jmp", 1, 0);
    tick();
    RST = 1'b1;
    applyStimulus(32'h708, 0, 0, 0, 0, 0, 0);
    checkFlow("rd_rst", 32'h70C, 0, 0, 0);
    tick();
    RST = 1'b0;
    applyStimulus(32'h800, 0, 0, 0, 0, 0, 1);
    checkFlow("rd_after", 32'h804, 0, 0, 0);
    tick();

    // PC wrap to zero raises the sticky target error
    applyStimulus(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1);
    checkFlow("wrap", 32'h0, 0, 0, 0);
    checkOutput("wrap_err_pre", {31'b0, tgt_err}, 32'h0);
    tick();
    checkOutput("wrap_err_set", {31'b0, tgt_err}, 32'h1);
    applyStimulus(32'h100, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    checkOutput("wrap_err_hold", {31'b0, tgt_err}, 32'h1);
    RST = 1'b1;
    tick();
    checkOutput("wrap_err_clr", {31'b0, tgt_err}, 32'h0);
    RST = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: WL, 32, datapath/address width.
REQ-002 Parameter: LU_CYC, 1, stall cycles per load-use hazard pulse (1..7).
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 PC  in  WL  current PC from the program counter register.
REQ-006 br_taken  in  1  EX-stage branch resolved taken.
REQ-007 br_target  in  WL  EX-stage branch target.
REQ-008 jmp  in  1  ID-stage unconditional jump.
REQ-009 jmp_target  in  WL  ID-stage jump target.
REQ-010 lu_hazard  in  1  ID/EX load-use hazard pulse.
REQ-011 imem_ready  in  1  instruction memory can accept a fetch this cycle.
REQ-012 PC_  out  WL  next-PC value to the PC register.
REQ-013 stall  out  1  hold PC and IF/ID.
REQ-014 flush_ifid  out  1  squash IF/ID.
REQ-015 flush_idex  out  1  squash ID/EX.
REQ-016 tgt_err  out  1  sticky: zero next-PC produced (PC register ignores 0).

Function
REQ-017 States: RUN, HOLD (load-use count), MEMWAIT (imem not ready), REDIR (pending redirect awaiting imem_ready).
REQ-018 PC_, stall, and the flushes are combinational from state, pending registers, and inputs; the PC register consumes them at the same edge (0-cycle latency).
REQ-019 PC_ priority: br_taken -> br_target; else jmp -> jmp_target; else REDIR with imem_ready -> pending target; else PC+4.
REQ-020 PC+4 is modulo 2^WL; PC=FFFF_FFFC yields PC_=0.
REQ-021 br_taken overrides any stall: stall=0, flush_ifid=1, flush_idex=1 in that cycle, and the HOLD counter is cleared.
REQ-022 jmp (without br_taken): flush_ifid=1, flush_idex=0; if a stall is also active, the jump is captured as pending instead and no flush is issued.
REQ-023 br_taken and jmp in the same cycle: branch wins; jump is discarded.
REQ-024 lu_hazard in RUN: stall=1 in the same cycle, enter HOLD with counter=LU_CYC-1; stall stays high until the counter reaches 0, then return to RUN. lu_hazard during HOLD reloads the counter.
REQ-025 imem_ready=0 with no br_taken: stall=1, enter MEMWAIT; return to RUN on the first cycle with imem_ready=1 (stall=0 that cycle unless HOLD is still counting).
REQ-026 Redirect arriving while imem_ready=0: target latched into a pending register and state goes to REDIR; on imem_ready=1, PC_=pending, stall=0, flush_ifid=1, pending cleared.
REQ-027 Pending overwrite: a later br_taken replaces a pending jump; a later jmp never replaces a pending branch.
REQ-028 tgt_err sets on any cycle where stall=0 and PC_=0, and clears only on RST.

Reset
REQ-029 With RST high: state=RUN, HOLD counter=0, pending cleared, tgt_err=0, stall=0, flush_ifid=0, flush_idex=0; PC_=PC+4.
REQ-030 RST mid-HOLD, mid-MEMWAIT, or mid-REDIR discards all pending work; the first post-reset cycle behaves as RUN.

Structure
REQ-031 Shared package pc_seq_pkg holds the state enum, PC_INC=4, and the WL default.
REQ-032 One sub-module, stall_timer (load/reload/decrement/zero flag, 3-bit), implements the HOLD counter.

Verification
REQ-033 Sequential run: PC=0x100, no events -> PC_=0x104, stall=0, all flushes 0.
REQ-034 LU_CYC=2, lu_hazard pulse at PC=0x200 -> stall=1 for exactly 2 cycles, PC_ advances to 0x204 only after the stall drops.
REQ-035 br_taken(target 0x400) and jmp(target 0x800) in the same cycle during HOLD -> PC_=0x400, stall=0, flush_ifid=flush_idex=1, then state RUN.
REQ-036 imem_ready=0 for 3 cycles, jmp to 0x300 in cycle 1 -> stall=1 for 3 cycles; on ready, PC_=0x300 and flush_ifid=1 for one cycle.
REQ-037 PC=0xFFFF_FFFC, no events -> PC_=0, tgt_err=1 and held until RST.
REQ-038 RST asserted in REDIR with pending 0x500 -> after reset PC_=PC+4, pending target never issued.
